// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Default segment lengths describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam logic SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic SYNC_ACTIVE_HIGH = 1'b1;

   // Decoded raster outputs, carried as one word through the delay line.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active_video;
      logic line_start;
      logic frame_start;
   } sync_t;

   localparam int SYNC_W = $bits(sync_t);

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register of depth DLY with a per-bit reset value.
// DLY=0 is a plain wire. 'tap' is the word that q will take on the next
// enabled edge, so callers can act in step with the delayed output.
module vga_sync_delay #(
   parameter int             W       = 5,
   parameter int             DLY     = 0,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] tap
);

   generate
      if (DLY == 0) begin : g_pass
         wire unused_ctl = ^{clk, rst, en};
         assign q   = d;
         assign tap = d;
      end else begin : g_shift
         logic [W-1:0] stage [DLY];

         // Shift one stage per pixel tick; hold otherwise.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < DLY; i++) stage[i] <= RST_VAL;
            end else if (en) begin
               stage[0] <= d;
               for (int i = 1; i < DLY; i++) stage[i] <= stage[i-1];
            end
         end

         assign q = stage[DLY-1];

         if (DLY == 1) begin : g_tap_in
            assign tap = d;
         end else begin : g_tap_stage
            assign tap = stage[DLY-2];
         end
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// x/y count the raster; sync/blank/strobe decode is registered from the next
// counter value so it is coherent with x/y, then optionally delayed by
// PIPE_DLY pixel ticks so x/y lead the outputs by the framebuffer latency.
// Optional frame counter: define VGA_FRAME_CNT_EN.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic HS_POL   = SYNC_ACTIVE_LOW,
   parameter logic VS_POL   = SYNC_ACTIVE_LOW,
   parameter int   CW       = 10,
   parameter int   PIPE_DLY = 0,
   parameter int   FC_W     = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          active_video,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
   ,output logic [FC_W-1:0] frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int MAX_CNT = (H_TOTAL > V_TOTAL) ? H_TOTAL - 1 : V_TOTAL - 1;

   generate
      if ((2 ** CW) <= MAX_CNT) begin : g_bad_cw
         $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
      end
      if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
         $error("vga_timing_gen: PIPE_DLY must be 0..7");
      end
   endgenerate

   localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
   // One bit wider so a window ending exactly at TOTAL cannot wrap.
   localparam logic [CW:0]   X_ACT_END = (CW+1)'(H_ACTIVE);
   localparam logic [CW:0]   HS_START  = (CW+1)'(H_ACTIVE + H_FP);
   localparam logic [CW:0]   HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW:0]   Y_ACT_END = (CW+1)'(V_ACTIVE);
   localparam logic [CW:0]   VS_START  = (CW+1)'(V_ACTIVE + V_FP);
   localparam logic [CW:0]   VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

   localparam sync_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, default: 1'b0};

   logic [CW-1:0] x_nxt, y_nxt;
   sync_t         dec, dec_nxt, dly_q, dly_tap;

   // Next raster position and its decode.
   always_comb begin
      x_nxt   = (x == X_LAST) ? '0 : x + CW'(1);
      y_nxt   = y;
      if (x == X_LAST) y_nxt = (y == Y_LAST) ? '0 : y + CW'(1);
      dec_nxt = SYNC_IDLE;
      dec_nxt.hsync        = ({1'b0, x_nxt} >= HS_START && {1'b0, x_nxt} < HS_END) ? HS_POL : ~HS_POL;
      dec_nxt.vsync        = ({1'b0, y_nxt} >= VS_START && {1'b0, y_nxt} < VS_END) ? VS_POL : ~VS_POL;
      dec_nxt.active_video = ({1'b0, x_nxt} < X_ACT_END) && ({1'b0, y_nxt} < Y_ACT_END);
      dec_nxt.line_start   = (x_nxt == '0);
      dec_nxt.frame_start  = (x_nxt == '0) && (y_nxt == '0);
   end

   // Counters start at the last position so the first tick lands on (0,0).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x   <= X_LAST;
         y   <= Y_LAST;
         dec <= SYNC_IDLE;
      end else if (pix_en) begin
         x   <= x_nxt;
         y   <= y_nxt;
         dec <= dec_nxt;
      end
   end

   vga_sync_delay #(
      .W       (SYNC_W),
      .DLY     (PIPE_DLY),
      .RST_VAL (SYNC_IDLE)
   ) u_dly (
      .clk (clk),
      .rst (rst),
      .en  (pix_en),
      .d   (dec),
      .q   (dly_q),
      .tap (dly_tap)
   );

   assign hsync        = dly_q.hsync;
   assign vsync        = dly_q.vsync;
   assign active_video = dly_q.active_video;
   assign line_start   = dly_q.line_start;
   assign frame_start  = dly_q.frame_start;

`ifdef VGA_FRAME_CNT_EN
   // frame_start as it will appear on the output after this edge.
   logic fs_out_nxt;
   assign fs_out_nxt = (PIPE_DLY == 0) ? dec_nxt.frame_start : dly_tap.frame_start;

   // Count frames in step with the delayed frame_start strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= '0;
      end else if (pix_en && fs_out_nxt) begin
         frame_cnt <= frame_cnt + FC_W'(1);
      end
   end
`else
   wire unused_tap = ^dly_tap;
   localparam int unused_fc_w = FC_W;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance free-running and a
// small-raster instance (PIPE_DLY=3, active-high hsync, FC_W=2) with random
// pix_en gaps and a mid-frame reset, both compared every cycle against an
// arithmetic raster model indexed by the number of pixel ticks since reset.
module tb_vga_timing_gen;

   typedef struct {
      int ha, hf, hsy, hb, va, vf, vsy, vb;
      bit hp, vp;
      int dly, fcw;
   } cfg_t;

   typedef struct {
      int x, y;
      bit hs, vs, av, ls, fs;
      int fc;
   } ref_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, pix_a, pix_b;
   logic [9:0] xa, ya;
   logic [4:0] xb, yb;
   logic hs_a, vs_a, av_a, ls_a, fs_a;
   logic hs_b, vs_b, av_b, ls_b, fs_b;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] fc_a;
   logic [1:0]  fc_b;
`endif

   vga_timing_gen u_dut_a (
      .clk          (clk),
      .rst          (rst_a),
      .pix_en       (pix_a),
      .x            (xa),
      .y            (ya),
      .hsync        (hs_a),
      .vsync        (vs_a),
      .active_video (av_a),
      .line_start   (ls_a),
      .frame_start  (fs_a)
`ifdef VGA_FRAME_CNT_EN
      ,.frame_cnt   (fc_a)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
      .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
      .HS_POL   (1'b1), .VS_POL (1'b0),
      .CW       (5), .PIPE_DLY (3), .FC_W (2)
   ) u_dut_b (
      .clk          (clk),
      .rst          (rst_b),
      .pix_en       (pix_b),
      .x            (xb),
      .y            (yb),
      .hsync        (hs_b),
      .vsync        (vs_b),
      .active_video (av_b),
      .line_start   (ls_b),
      .frame_start  (fs_b)
`ifdef VGA_FRAME_CNT_EN
      ,.frame_cnt   (fc_b)
`endif
   );

   int n_chk = 0;
   int n_err = 0;
   cfg_t cfg_a, cfg_b;
   int t_a, t_b;

   // Pixel ticks since reset, per instance.
   always @(posedge clk or negedge rst_a)
      if (!rst_a) t_a <= 0; else if (pix_a) t_a <= t_a + 1;
   always @(posedge clk or negedge rst_b)
      if (!rst_b) t_b <= 0; else if (pix_b) t_b <= t_b + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         if (n_err <= 30)
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   // Raster state after t pixel ticks; outputs lag the counters by c.dly.
   function automatic ref_t model(cfg_t c, int t);
      ref_t r;
      int ht, vt, ft, p, u, xx, yy;
      ht = c.ha + c.hf + c.hsy + c.hb;
      vt = c.va + c.vf + c.vsy + c.vb;
      ft = ht * vt;
      if (t == 0) begin
         r.x = ht - 1;
         r.y = vt - 1;
      end else begin
         p   = (t - 1) % ft;
         r.x = p % ht;
         r.y = p / ht;
      end
      r.hs = ~c.hp; r.vs = ~c.vp;
      r.av = 1'b0;  r.ls = 1'b0; r.fs = 1'b0;
      r.fc = 0;
      u = t - c.dly;
      if (u > 0) begin
         p  = (u - 1) % ft;
         xx = p % ht;
         yy = p / ht;
         r.hs = (xx >= c.ha + c.hf && xx < c.ha + c.hf + c.hsy) ? c.hp : ~c.hp;
         r.vs = (yy >= c.va + c.vf && yy < c.va + c.vf + c.vsy) ? c.vp : ~c.vp;
         r.av = (xx < c.ha) && (yy < c.va);
         r.ls = (xx == 0);
         r.fs = (xx == 0) && (yy == 0);
         r.fc = ((u - 1) / ft + 1) % (1 << c.fcw);
      end
      return r;
   endfunction

   task automatic check_a();
      ref_t r;
      r = model(cfg_a, t_a);
      check("a.x",  32'(xa),   32'(r.x));
      check("a.y",  32'(ya),   32'(r.y));
      check("a.hs", 32'(hs_a), 32'(r.hs));
      check("a.vs", 32'(vs_a), 32'(r.vs));
      check("a.av", 32'(av_a), 32'(r.av));
      check("a.ls", 32'(ls_a), 32'(r.ls));
      check("a.fs", 32'(fs_a), 32'(r.fs));
`ifdef VGA_FRAME_CNT_EN
      check("a.fc", 32'(fc_a), 32'(r.fc));
`endif
   endtask

   task automatic check_b();
      ref_t r;
      r = model(cfg_b, t_b);
      check("b.x",  32'(xb),   32'(r.x));
      check("b.y",  32'(yb),   32'(r.y));
      check("b.hs", 32'(hs_b), 32'(r.hs));
      check("b.vs", 32'(vs_b), 32'(r.vs));
      check("b.av", 32'(av_b), 32'(r.av));
      check("b.ls", 32'(ls_b), 32'(r.ls));
      check("b.fs", 32'(fs_b), 32'(r.fs));
`ifdef VGA_FRAME_CNT_EN
      check("b.fc", 32'(fc_b), 32'(r.fc));
`endif
   endtask

   int hs_low, hs_first, av_cnt;

   initial begin
      cfg_a = '{ha: 640, hf: 16, hsy: 96, hb: 48, va: 480, vf: 10, vsy: 2, vb: 33,
                hp: 1'b0, vp: 1'b0, dly: 0, fcw: 16};
      cfg_b = '{ha: 8, hf: 2, hsy: 3, hb: 2, va: 6, vf: 1, vsy: 2, vb: 1,
                hp: 1'b1, vp: 1'b0, dly: 3, fcw: 2};
      hs_low = 0; hs_first = -1; av_cnt = 0;
      rst_a = 1'b0; rst_b = 1'b0; pix_a = 1'b0; pix_b = 1'b0;

      repeat (3) @(negedge clk);
      check_a();
      check_b();
      check("b.hs_rst", 32'(hs_b), 32'd0);
      rst_a = 1'b1;
      rst_b = 1'b1;

      for (int cyc = 0; cyc < 2200; cyc++) begin
         @(negedge clk);
         check_a();
         check_b();
         if (t_a >= 1 && t_a <= 800) begin
            if (hs_a == 1'b0) begin
               hs_low++;
               if (hs_first < 0) hs_first = int'(xa);
            end
            if (av_a) av_cnt++;
         end
         if (t_a == 801) begin
            check("a.wrap_x", 32'(xa), 32'd0);
            check("a.wrap_y", 32'(ya), 32'd1);
         end
         if (cyc == 1500) begin
            #2 rst_b = 1'b0;
            #1 check_b();
            check("b.rst_x", 32'(xb), 32'd14);
            check("b.rst_y", 32'(yb), 32'd9);
         end
         if (cyc == 1504) rst_b = 1'b1;
         pix_a = 1'b1;
         pix_b = 1'($urandom_range(0, 1));
      end

      check("a.hs_low_len",   32'(hs_low),   32'd96);
      check("a.hs_first_x",   32'(hs_first), 32'd656);
      check("a.av_line_len",  32'(av_cnt),   32'd640);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Parametrised VGA raster timing generator; successor to the fixed 640x480 sync generator.
- Produces pixel/line counters, programmable-polarity hsync/vsync, active-video flag, line/frame start strobes, and a configurable output delay for the decode strobes.
- Sits between the pixel clock domain and the framebuffer read / pixel output path of the coprocessor display subsystem.

## Interface
Parameters:
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal segment lengths in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical segment lengths in lines.
- HS_POL, 0; VS_POL, 0: active sync level (0 = active-low).
- CW, 10: counter width. Must satisfy 2^CW > max(H_TOTAL-1, V_TOTAL-1); violations are an elaboration error.
- PIPE_DLY, 0: delay of the decoded outputs, in pix_en ticks (0..7).
- FC_W, 16: frame counter width.

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  reset; asynchronous, active-low.
- pix_en  in  1  pixel tick. All state advances only on clk edges where pix_en=1.
- x  out  CW  current horizontal position, 0..H_TOTAL-1.
- y  out  CW  current line, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, level per HS_POL.
- vsync  out  1  vertical sync, level per VS_POL.
- active_video  out  1  high when the pixel is in the visible area.
- line_start  out  1  one-tick strobe at x==0.
- frame_start  out  1  one-tick strobe at x==0 and y==0.
- frame_cnt  out  FC_W  frame count; present only with VGA_FRAME_CNT_EN.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counting on each pix_en tick:
  - x increments.
  - At x==H_TOTAL-1, x wraps to 0 and y increments.
  - At y==V_TOTAL-1 with x==H_TOTAL-1, y wraps to 0.
  - There is no overshoot past TOTAL-1.
- Decode is computed from the next counter value and registered on the same edge, so undelayed outputs are coherent with x/y:
  - hsync is active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
  - active_video iff x<H_ACTIVE and y<V_ACTIVE.
- PIPE_DLY>0 delays hsync, vsync, active_video, line_start and frame_start by PIPE_DLY pix_en ticks.
  - x/y are never delayed; they lead the outputs, so framebuffer read latency is hidden.
- pix_en=0: all registers, including the delay line, hold their values.

## Timing
- Reset (asynchronous assert, any cycle, including mid-frame):
  - x=H_TOTAL-1, y=V_TOTAL-1.
  - hsync=~HS_POL, vsync=~VS_POL.
  - active_video=0, line_start=0, frame_start=0, frame_cnt=0.
  - Delay-line stages reset to the same inactive values.
- First pix_en tick after reset release: x=0, y=0. With PIPE_DLY=0, frame_start=line_start=active_video=1 on that same edge.
- Undelayed latency from counter to decode is zero ticks; delayed latency is exactly PIPE_DLY ticks.
- Strobes stay high for exactly one pix_en period. They persist across pix_en=0 cycles until the next tick.
- Line period is H_TOTAL ticks; frame period is H_TOTAL*V_TOTAL ticks.
- Default hsync low at x=656..751; default vsync low at y=490..491.

## Configuration
- VGA_FRAME_CNT_EN defined:
  - frame_cnt port and register exist.
  - frame_cnt increments (mod 2^FC_W) on the tick where the delayed frame_start is asserted.
  - First frame after reset reads 1.
- VGA_FRAME_CNT_EN undefined: port and logic are absent; all other behaviour is identical.

## Structure
- Package vga_timing_pkg holds:
  - Default 640x480@60 segment constants.
  - Polarity constants (SYNC_ACTIVE_LOW/HIGH).
  - A struct or typedef bundling {hsync, vsync, active_video, line_start, frame_start} for the delay line.
- Sub-module vga_sync_delay: enable-gated shift register of depth PIPE_DLY with a reset value per bit. PIPE_DLY=0 is a pass-through.

## Test plan
- Reset, release, one pix_en tick -> x=0, y=0, frame_start=1, line_start=1, active_video=1, hsync=vsync=1.
- Free-run one line at defaults:
  - hsync low for exactly 96 ticks starting at x=656.
  - active_video high 640 ticks.
  - x wraps 799->0 with y 0->1 on the same edge.
- Run to y=524, x=799, one tick -> x=0, y=0, frame_start=1; vsync low exactly for y=490..491 (1600 ticks).
- PIPE_DLY=3, HS_POL=1 -> x=656 precedes hsync rising (active-high) by exactly 3 ticks; hsync reset value is 0.
- pix_en toggled 1/0/0/1 pseudo-randomly -> trace matches the pix_en=1 reference with idle cycles removed; strobes are held through gaps.
- Assert rst at x=300, y=200 -> all outputs at reset values immediately; after release the sequence restarts at (0,0). With VGA_FRAME_CNT_EN, frame_cnt=0 then 1 on the first frame_start, wrapping after 2^FC_W frames (checked at FC_W=2).
